// File: rtl/dnn_scorer_pkg.sv
// Shared types and helpers for the DNN output scorer.
// The L1 helper is only referenced when SCORER_L1_EN is defined.
package dnn_scorer_pkg;

    typedef enum logic [1:0] {
        SYNC,
        ACCUM,
        REPORT
    } scorer_state_t;

    // First cycle of a block that carries valid network outputs.
    localparam int FIRST_OUT_CYC = 2;
    localparam int L1_CALC_W     = 64;

    // |y - act| for a binary target. Overshoot above 1.0 on a y=1 target
    // counts as zero error rather than wrapping negative.
    function automatic logic [L1_CALC_W-1:0] abs_err_l1(
        input logic                 y,
        input logic [L1_CALC_W-1:0] act,
        input int unsigned          frac_bits
    );
        logic [L1_CALC_W-1:0] one;
        one = L1_CALC_W'(1) << frac_bits;
        if (!y) begin
            return act;
        end
        return (act >= one) ? '0 : one - act;
    endfunction

endpackage

// File: rtl/dnn_output_scorer_window.sv
// sliding_window_counter: shift register of the last WINDOW per-case
// correct bits with an incrementally maintained population count.
module sliding_window_counter
    import dnn_scorer_pkg::*;
#(
    parameter  int WINDOW = 100,
    localparam int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_bit,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full
);

    logic [WINDOW-1:0] r_hist;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_fill;

    // NOTE: the history is reset on purpose; empty slots must read as 0 so
    // the count stays exact while the window is still filling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist  <= '0;
            r_count <= '0;
            r_fill  <= '0;
        end else if (i_push) begin
            // NOTE: non-blocking assignments, so r_hist[WINDOW-1] here is the
            // entry leaving the window, not the one just shifted in.
            r_count <= r_count + CNT_W'(i_bit) - CNT_W'(r_hist[WINDOW-1]);
            r_hist  <= {r_hist[WINDOW-2:0], i_bit};
            if (r_fill != CNT_W'(WINDOW)) begin
                r_fill <= r_fill + CNT_W'(1);
            end
        end
    end

    assign o_count = r_count;
    assign o_full  = (r_fill == CNT_W'(WINDOW));

endmodule

// File: rtl/dnn_output_scorer.sv
// dnn_output_scorer: scores each training case of the DNN output stream.
// Optional macro SCORER_L1_EN adds the act_l input and l1_case output.
module dnn_output_scorer
    import dnn_scorer_pkg::*;
#(
    parameter  int CPC         = 18,
    parameter  int OUT_PER_CYC = 1,
    parameter  int WINDOW      = 100,
    parameter  int CNT_W       = 32,
    parameter  int WIDTH       = 32,
    parameter  int FRAC_BITS   = 21,
    localparam int IDX_W       = $clog2(CPC),
    localparam int RC_W        = $clog2(WINDOW + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [IDX_W-1:0]       cycle_index,
    input  logic [OUT_PER_CYC-1:0] a_out,
    input  logic [OUT_PER_CYC-1:0] y_out,
`ifdef SCORER_L1_EN
    input  logic [WIDTH-1:0]       act_l,
    output logic [WIDTH+IDX_W-1:0] l1_case,
`endif
    output logic                   case_done,
    output logic                   case_correct,
    output logic [CNT_W-1:0]       num_cases,
    output logic [CNT_W-1:0]       total_error,
    output logic [RC_W-1:0]        recent_correct,
    output logic                   window_full
);

    if (FRAC_BITS >= WIDTH) begin : g_frac_check
        $error("FRAC_BITS must be smaller than WIDTH");
    end

    scorer_state_t    r_state;
    logic             r_err;
    logic [IDX_W-1:0] r_prev_idx;

    logic w_valid_cyc;
    logic w_last_cyc;
    logic w_backward;
    logic w_mismatch;
    logic w_accum_cyc;
    logic w_report_edge;
    logic w_case_correct;

    assign w_valid_cyc    = (cycle_index >= IDX_W'(FIRST_OUT_CYC)) &&
                            (cycle_index <= IDX_W'(CPC - 1));
    assign w_last_cyc     = (cycle_index == IDX_W'(CPC - 1));
    assign w_backward     = (cycle_index < r_prev_idx);
    assign w_mismatch     = |(a_out ^ y_out);
    assign w_accum_cyc    = (r_state == ACCUM) && !w_backward && w_valid_cyc;
    assign w_report_edge  = w_accum_cyc && w_last_cyc;
    // The final output cycle is folded in directly, it never reaches r_err.
    assign w_case_correct = !(r_err | w_mismatch);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= SYNC;
            r_err        <= 1'b0;
            r_prev_idx   <= '0;
            case_done    <= 1'b0;
            case_correct <= 1'b0;
            num_cases    <= '0;
            total_error  <= '0;
        end else begin
            r_prev_idx <= cycle_index;
            case_done  <= 1'b0;
            case (r_state)
                SYNC: begin
                    r_err <= 1'b0;
                    if (cycle_index == '0) begin
                        r_state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (w_backward) begin
                        r_state <= SYNC;
                        r_err   <= 1'b0;
                    end else if (w_report_edge) begin
                        r_state      <= REPORT;
                        case_done    <= 1'b1;
                        case_correct <= w_case_correct;
                        if (num_cases != '1) begin
                            num_cases <= num_cases + CNT_W'(1);
                        end
                        if (!w_case_correct && total_error != '1) begin
                            total_error <= total_error + CNT_W'(1);
                        end
                    end else if (w_accum_cyc) begin
                        r_err <= r_err | w_mismatch;
                    end
                end
                REPORT: begin
                    r_state <= ACCUM;
                    r_err   <= 1'b0;
                end
                default: r_state <= SYNC;
            endcase
        end
    end

    sliding_window_counter #(
        .WINDOW (WINDOW)
    ) u_window (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_report_edge),
        .i_bit   (w_case_correct),
        .o_count (recent_correct),
        .o_full  (window_full)
    );

`ifdef SCORER_L1_EN
    localparam int L1_W = WIDTH + IDX_W;

    if (OUT_PER_CYC != 1) begin : g_l1_check
        $error("SCORER_L1_EN requires OUT_PER_CYC == 1");
    end

    logic [L1_W-1:0] r_l1_acc;
    logic [L1_W-1:0] w_l1_term;

    assign w_l1_term = L1_W'(abs_err_l1(y_out[0], L1_CALC_W'(act_l), FRAC_BITS));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_l1_acc <= '0;
            l1_case  <= '0;
        end else if (w_report_edge) begin
            l1_case  <= r_l1_acc + w_l1_term;
            r_l1_acc <= '0;
        end else if (w_accum_cyc) begin
            r_l1_acc <= r_l1_acc + w_l1_term;
        end else if (r_state != ACCUM || w_backward) begin
            r_l1_acc <= '0;
        end
    end
`endif

endmodule
